// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory-access stage: bus widths, load encodings and the
// request-tracking state encoding.
package mem_stage_pkg;

   localparam int unsigned ES_TO_MS_BUS_WD = 76;
   localparam int unsigned MS_TO_WS_BUS_WD = 70;

   typedef enum logic [2:0] {
      LdW  = 3'b000,
      LdB  = 3'b001,
      LdH  = 3'b010,
      LdBu = 3'b011,
      LdHu = 3'b100
   } ld_type_e;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StHold
   } ms_state_e;

   typedef struct packed {
      logic        mem_req;
      ld_type_e    ld_type;
      logic        store_op;
      logic        load_op;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] alu_result;
      logic [31:0] pc;
   } es_to_ms_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half out of a 32-bit read word and sign- or zero-extends it.
module mem_stage_load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  ld_type_e    ld_type,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      unique case (offset)
         2'd0: byte_sel = rdata[7:0];
         2'd1: byte_sel = rdata[15:8];
         2'd2: byte_sel = rdata[23:16];
         2'd3: byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      // Halfword misalignment is not trapped here; offset[0] is simply ignored.
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      result = rdata;
      case (ld_type)
         LdW:     result = rdata;
         LdB:     result = {{24{byte_sel[7]}}, byte_sel};
         LdH:     result = {{16{half_sel[15]}}, half_sel};
         LdBu:    result = {24'd0, byte_sel};
         LdHu:    result = {16'd0, half_sel};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, tracks its single outstanding
// data-SRAM request, aligns load data and forwards the result to writeback and decode.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   input  logic                       data_sram_data_ok,
   input  logic [31:0]                data_sram_rdata,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic                       ms_fwd_valid,
   output logic                       ms_fwd_ready,
   output logic [4:0]                 ms_fwd_dest,
   output logic [31:0]                ms_fwd_value
);

   es_to_ms_t   es_in;
   es_to_ms_t   bus_q;
   logic        ms_valid_q;
   ms_state_e   state_q, state_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_q;

   logic        ms_ready_go;
   logic        latch_mem;
   logic        resp_capture;
   logic [31:0] load_src;
   logic [31:0] load_data;
   logic [31:0] final_result;
   logic        gr_we_eff;

   assign es_in = es_to_ms_bus;

   assign ms_ready_go = !bus_q.mem_req
                     || (state_q == StWait && data_sram_data_ok)
                     || state_q == StHold;
   assign ms_allowin  = !ms_valid_q || (ms_ready_go && ws_allowin);
   assign latch_mem   = ms_allowin && es_to_ms_valid && es_in.mem_req;

   always_comb begin
      state_d      = state_q;
      resp_valid_d = resp_valid_q;
      resp_capture = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (latch_mem) state_d = StWait;
         end
         StWait: begin
            if (data_sram_data_ok) begin
               if (ws_allowin) begin
                  // Hand-off and a new request can coincide; stay in WAIT without a bubble.
                  state_d = latch_mem ? StWait : StIdle;
               end else begin
                  state_d      = StHold;
                  resp_valid_d = 1'b1;
                  resp_capture = 1'b1;
               end
            end
         end
         StHold: begin
            if (ws_allowin) begin
               state_d      = latch_mem ? StWait : StIdle;
               resp_valid_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_valid_q   <= 1'b0;
         state_q      <= StIdle;
         resp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= resp_valid_d;
         if (ms_allowin) ms_valid_q <= es_to_ms_valid;
      end
   end

   // Payload registers carry no reset; their contents are qualified by ms_valid_q.
   always_ff @(posedge clk) begin
      if (ms_allowin)   bus_q  <= es_in;
      if (resp_capture) resp_q <= data_sram_rdata;
   end

   assign load_src = resp_valid_q ? resp_q : data_sram_rdata;

   mem_stage_load_align u_load_align (
      .rdata   (load_src),
      .offset  (bus_q.alu_result[1:0]),
      .ld_type (bus_q.ld_type),
      .result  (load_data)
   );

   assign final_result = bus_q.load_op ? load_data : bus_q.alu_result;
   assign gr_we_eff    = bus_q.gr_we && !bus_q.store_op;

   assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
   assign ms_to_ws_bus   = {gr_we_eff, bus_q.dest, final_result, bus_q.pc};

   assign ms_fwd_valid = ms_valid_q && gr_we_eff && (bus_q.dest != 5'd0);
   assign ms_fwd_ready = ms_valid_q && (!bus_q.load_op || ms_ready_go);
   assign ms_fwd_dest  = bus_q.dest;
   assign ms_fwd_value = final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage with a behavioural load/handshake model.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        ws_allowin = 1'b0;
   logic        ms_allowin;
   logic        es_to_ms_valid = 1'b0;
   logic [75:0] es_to_ms_bus = '0;
   logic        data_sram_data_ok = 1'b0;
   logic [31:0] data_sram_rdata = '0;
   logic        ms_to_ws_valid;
   logic [69:0] ms_to_ws_bus;
   logic        ms_fwd_valid;
   logic        ms_fwd_ready;
   logic [4:0]  ms_fwd_dest;
   logic [31:0] ms_fwd_value;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk               (clk),
      .resetn            (resetn),
      .ws_allowin        (ws_allowin),
      .ms_allowin        (ms_allowin),
      .es_to_ms_valid    (es_to_ms_valid),
      .es_to_ms_bus      (es_to_ms_bus),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .ms_fwd_valid      (ms_fwd_valid),
      .ms_fwd_ready      (ms_fwd_ready),
      .ms_fwd_dest       (ms_fwd_dest),
      .ms_fwd_value      (ms_fwd_value)
   );

   typedef struct {
      logic [69:0] bus;
      bit          mem;
      bit          load;
      bit          fwdv;
      logic [4:0]  dest;
   } exp_t;

   typedef struct {
      int          kind;   // 0 alu, 1 load, 2 store
      logic [2:0]  ldt;
      logic [31:0] alu;
      logic [31:0] rd;
   } dir_t;

   exp_t        q[$];
   dir_t        dir_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   bit          got = 0;       // response for the instruction at q[0] has arrived
   bit          running = 0;
   bit          issue = 1;
   bit          pend = 0;
   int          cnt = 0;
   logic [31:0] rd_out = '0;
   logic [31:0] cur_rd = '0;
   logic        has, rg;

   task automatic check(string name, logic [69:0] act, logic [69:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] load_ref(logic [31:0] d, logic [1:0] off, logic [2:0] t);
      int unsigned b, h;
      int          s;
      b = (d >> (8 * off)) & 32'hff;
      h = (d >> (16 * int'(off[1]))) & 32'hffff;
      case (t)
         3'd0: return d;
         3'd1: begin s = (b >= 128) ? int'(b) - 256 : int'(b); return 32'(s); end
         3'd2: begin s = (h >= 32768) ? int'(h) - 65536 : int'(h); return 32'(s); end
         3'd3: return 32'(b);
         3'd4: return 32'(h);
         default: return d;
      endcase
   endfunction

   task automatic gen();
      dir_t        it;
      logic        mem, ld, st, gwe;
      logic [4:0]  dest;
      logic [31:0] pc;
      if (dir_q.size() > 0) begin
         it = dir_q.pop_front();
      end else begin
         it.kind = $urandom_range(0, 2);
         it.ldt  = 3'($urandom_range(0, 4));
         it.alu  = $urandom;
         it.rd   = $urandom;
      end
      mem  = (it.kind != 0);
      ld   = (it.kind == 1);
      st   = (it.kind == 2);
      gwe  = st ? 1'b0 : ($urandom_range(0, 7) != 0);
      dest = 5'($urandom_range(0, 31));
      pc   = $urandom;
      es_to_ms_bus = {mem, it.ldt, st, ld, gwe, dest, it.alu, pc};
      cur_rd       = it.rd;
   endtask

   task automatic push_expected(logic [75:0] b, logic [31:0] rd);
      exp_t        e;
      logic [31:0] alu, fin;
      logic        gwe;
      alu    = b[63:32];
      fin    = b[70] ? load_ref(rd, alu[1:0], b[74:72]) : alu;
      gwe    = b[69] & ~b[71];
      e.bus  = {gwe, b[68:64], fin, b[31:0]};
      e.mem  = b[75];
      e.load = b[70];
      e.dest = b[68:64];
      e.fwdv = gwe && (b[68:64] != 5'd0);
      q.push_back(e);
   endtask

   // One clock of stimulus: sample acceptance away from the edge, then drive after it.
   task automatic step();
      logic acc;
      @(negedge clk);
      acc = es_to_ms_valid && ms_allowin;
      @(posedge clk);
      #1;
      if (acc) begin
         push_expected(es_to_ms_bus, cur_rd);
         if (es_to_ms_bus[75]) begin
            pend   = 1;
            cnt    = $urandom_range(0, 3);
            rd_out = cur_rd;
         end
      end
      if (pend && cnt == 0) begin
         data_sram_data_ok = 1'b1;
         data_sram_rdata   = rd_out;
         pend              = 0;
         got               = 1;
      end else begin
         data_sram_data_ok = 1'b0;
         data_sram_rdata   = $urandom;
         if (pend) cnt--;
      end
      ws_allowin = issue ? ($urandom_range(0, 9) < 7) : 1'b1;
      if (!es_to_ms_valid || acc) begin
         if (issue && $urandom_range(0, 9) < 7) begin
            gen();
            es_to_ms_valid = 1'b1;
         end else begin
            es_to_ms_valid = 1'b0;
         end
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (running && resetn) begin
         has = (q.size() > 0);
         rg  = has && (!q[0].mem || got);
         check("ws_valid", 70'(ms_to_ws_valid), 70'(rg));
         check("allowin", 70'(ms_allowin), 70'(!has || (rg && ws_allowin)));
         if (has) begin
            check("fwd_valid", 70'(ms_fwd_valid), 70'(q[0].fwdv));
            if (q[0].fwdv) check("fwd_dest", 70'(ms_fwd_dest), 70'(q[0].dest));
            check("fwd_ready", 70'(ms_fwd_ready), 70'(!q[0].load || got));
            if (rg) check("fwd_value", 70'(ms_fwd_value), 70'(q[0].bus[63:32]));
            if (rg && ws_allowin) begin
               check("ws_bus", ms_to_ws_bus, q[0].bus);
               void'(q.pop_front());
               got = 0;
            end
         end else begin
            check("fwd_valid_idle", 70'(ms_fwd_valid), 70'(1'b0));
         end
      end
   end

   // A response may only arrive while a request is outstanding.
   always @(posedge clk) begin
      if (resetn && data_sram_data_ok) begin
         n_cmp++;
         assert (dut.state_q == StWait)
         else begin
            n_err++;
            $display("FAIL data_ok_outside_wait: state %0d expected %0d", dut.state_q, StWait);
         end
      end
   end

   initial begin
      bit found;
      dir_q.push_back('{0, 3'd0, 32'h0000_1234, 32'h0});
      dir_q.push_back('{1, 3'd1, 32'h1000_0003, 32'h80FF_FF7F});
      dir_q.push_back('{1, 3'd4, 32'h1000_0002, 32'hBEEF_0000});
      dir_q.push_back('{1, 3'd0, 32'h1000_0000, 32'hCAFE_F00D});
      dir_q.push_back('{1, 3'd0, 32'h1000_0004, 32'h1234_5678});
      dir_q.push_back('{2, 3'd0, 32'h1000_0008, 32'h0});
      dir_q.push_back('{0, 3'd0, 32'h0000_0042, 32'h0});

      #3;
      check("rst_ws_valid", 70'(ms_to_ws_valid), 70'(1'b0));
      check("rst_fwd_valid", 70'(ms_fwd_valid), 70'(1'b0));
      check("rst_fwd_ready", 70'(ms_fwd_ready), 70'(1'b0));
      check("rst_allowin", 70'(ms_allowin), 70'(1'b1));
      @(negedge clk);
      resetn  = 1'b1;
      running = 1;

      repeat (1500) step();

      // Reset asserted while a request is outstanding
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         step();
         if (pend) found = 1;
      end
      check("found_wait", 70'(found), 70'(1'b1));
      if (found) begin
         #2;
         resetn = 1'b0;
         #1;
         check("midrst_ws_valid", 70'(ms_to_ws_valid), 70'(1'b0));
         check("midrst_fwd_valid", 70'(ms_fwd_valid), 70'(1'b0));
         check("midrst_fwd_ready", 70'(ms_fwd_ready), 70'(1'b0));
         check("midrst_allowin", 70'(ms_allowin), 70'(1'b1));
         q.delete();
         got               = 0;
         pend              = 0;
         es_to_ms_valid    = 1'b0;
         data_sram_data_ok = 1'b0;
         repeat (2) @(negedge clk);
         resetn = 1'b1;
         #1;
         check("post_rst_allowin", 70'(ms_allowin), 70'(1'b1));
         check("post_rst_ws_valid", 70'(ms_to_ws_valid), 70'(1'b0));
         check("post_rst_state", 70'(dut.state_q), 70'(StIdle));
      end

      repeat (1500) step();

      issue = 0;
      repeat (30) step();
      check("drained", 70'(q.size()), 70'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
